// File: rtl/tqvp_htfab_vga_sync_gen.sv
// VGA 640x480@60 timing generator for the baby VGA peripheral: line/frame counters, sync strobes,
// 32x16 cell coordinates, blanking, read-phase counter and vblank interrupt. Define VGA_SYNC_INVERT_EN for active-high syncs.
module tqvp_htfab_vga_sync_gen #(
    parameter int H_ACTIVE = 1628,
    parameter int H_FP     = 41,
    parameter int H_SYNC   = 244,
    parameter int H_BP     = 121,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cli,
    input  logic [5:0] pix_div,
    input  logic [5:0] row_div,
    output logic [4:0] x_pos,
    output logic [3:0] y_pos,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [2:0] counter,
    output logic       interrupt
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

`ifdef VGA_SYNC_INVERT_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic [5:0]    sub_cnt, sub_nxt;
    logic [5:0]    line_cnt, line_nxt;
    logic [5:0]    pd_q, rd_q;
    logic [5:0]    pd_raw, pd_eff, rd_raw, rd_eff;
    logic          col_ovf, col_ovf_nxt;
    logic          row_ovf, row_ovf_nxt;
    logic [4:0]    x_nxt;
    logic [3:0]    y_nxt;
    logic          h_wrap, v_wrap, h_zero, set_cycle;
    logic          hsync_nxt, vsync_nxt, blank_nxt, int_nxt;
    logic [2:0]    counter_nxt;

    always_comb begin
        h_wrap = (int'(h_cnt) == H_TOTAL - 1);
        v_wrap = (int'(v_cnt) == V_TOTAL - 1);
        h_zero = (h_cnt == '0);
        h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt  = h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;

        // Divisors are taken live on the sampling cycle itself so the first step of a line/frame already uses them.
        pd_raw = h_zero ? pix_div : pd_q;
        pd_eff = (pd_raw == 6'd0) ? 6'd1 : pd_raw;
        rd_raw = (h_zero && v_cnt == '0) ? row_div : rd_q;
        rd_eff = (rd_raw == 6'd0) ? 6'd1 : rd_raw;

        sub_nxt     = sub_cnt;
        x_nxt       = x_pos;
        col_ovf_nxt = col_ovf;
        if (h_wrap) begin
            sub_nxt     = 6'd0;
            x_nxt       = 5'd0;
            col_ovf_nxt = 1'b0;
        end else if (sub_cnt == pd_eff - 6'd1) begin
            sub_nxt = 6'd0;
            if (x_pos == 5'd31) col_ovf_nxt = 1'b1;
            else                x_nxt       = x_pos + 5'd1;
        end else begin
            sub_nxt = sub_cnt + 6'd1;
        end

        line_nxt    = line_cnt;
        y_nxt       = y_pos;
        row_ovf_nxt = row_ovf;
        if (h_wrap) begin
            if (v_wrap) begin
                line_nxt    = 6'd0;
                y_nxt       = 4'd0;
                row_ovf_nxt = 1'b0;
            end else if (line_cnt == rd_eff - 6'd1) begin
                line_nxt = 6'd0;
                if (y_pos == 4'd15) row_ovf_nxt = 1'b1;
                else                y_nxt       = y_pos + 4'd1;
            end else begin
                line_nxt = line_cnt + 6'd1;
            end
        end

        hsync_nxt = (int'(h_nxt) >= HS_START && int'(h_nxt) < HS_END) ? SYNC_ON : SYNC_OFF;
        vsync_nxt = (int'(v_nxt) >= VS_START && int'(v_nxt) < VS_END) ? SYNC_ON : SYNC_OFF;
        blank_nxt = (int'(h_nxt) >= H_ACTIVE) | (int'(v_nxt) >= V_ACTIVE) | col_ovf_nxt | row_ovf_nxt;
        counter_nxt = (h_nxt == '0) ? 3'd0 : counter + 3'd1;

        // A cli landing on the edge that sets the flag, or during the cycle it first shows, cannot clear it.
        set_cycle = h_zero && (int'(v_cnt) == V_ACTIVE);
        int_nxt   = ((h_nxt == '0) && (int'(v_nxt) == V_ACTIVE))
                  | (interrupt & (~cli | set_cycle));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            sub_cnt   <= 6'd0;
            line_cnt  <= 6'd0;
            pd_q      <= 6'd1;
            rd_q      <= 6'd1;
            col_ovf   <= 1'b0;
            row_ovf   <= 1'b0;
            x_pos     <= 5'd0;
            y_pos     <= 4'd0;
            hsync     <= SYNC_OFF;
            vsync     <= SYNC_OFF;
            blank     <= 1'b0;
            counter   <= 3'd0;
            interrupt <= 1'b0;
        end else begin
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            sub_cnt   <= sub_nxt;
            line_cnt  <= line_nxt;
            if (h_zero) pd_q <= pix_div;
            if (h_zero && v_cnt == '0) rd_q <= row_div;
            col_ovf   <= col_ovf_nxt;
            row_ovf   <= row_ovf_nxt;
            x_pos     <= x_nxt;
            y_pos     <= y_nxt;
            hsync     <= hsync_nxt;
            vsync     <= vsync_nxt;
            blank     <= blank_nxt;
            counter   <= counter_nxt;
            interrupt <= int_nxt;
        end
    end

endmodule

// File: tb/tb_tqvp_htfab_vga_sync_gen.sv
// Bench for tqvp_htfab_vga_sync_gen: a full-size instance for line timing and a shrunken instance for frame,
// interrupt and reset behaviour. Honours VGA_SYNC_INVERT_EN for sync polarity.
module tb_tqvp_htfab_vga_sync_gen;

`ifdef VGA_SYNC_INVERT_EN
    localparam logic SON = 1'b1;
`else
    localparam logic SON = 1'b0;
`endif
    localparam logic SOFF = ~SON;

    // Shrunken timing: 60 clocks/line, 58 lines/frame, hsync [44,50), vsync lines [51,53), vblank at line 48.
    localparam int SH_TOT = 60;
    localparam int SV_TOT = 58;
    localparam int S_FRAME = SH_TOT * SV_TOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cli = 1'b0;
    logic [5:0] pix_div = 6'd50;
    logic [5:0] row_div = 6'd30;

    logic [4:0] b_x, s_x;
    logic [3:0] b_y, s_y;
    logic       b_hs, b_vs, b_bl, b_int, s_hs, s_vs, s_bl, s_int;
    logic [2:0] b_cnt, s_cnt;

    tqvp_htfab_vga_sync_gen u_big (
        .clk(clk), .rst_n(rst_n), .cli(cli), .pix_div(pix_div), .row_div(row_div),
        .x_pos(b_x), .y_pos(b_y), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
        .counter(b_cnt), .interrupt(b_int)
    );

    tqvp_htfab_vga_sync_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(10),
        .V_ACTIVE(48), .V_FP(3), .V_SYNC(2), .V_BP(5)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .cli(cli), .pix_div(pix_div), .row_div(row_div),
        .x_pos(s_x), .y_pos(s_y), .hsync(s_hs), .vsync(s_vs), .blank(s_bl),
        .counter(s_cnt), .interrupt(s_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] pd;
        logic [4:0] x;
        logic       hs_act;
        logic       bl;
        logic [2:0] cnt;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   vs_cnt, nfall, fall0, fall1;
    logic prev_vs;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic reset_seq;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic go_to(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        vec_t vecs[25];
        int   h, ln, ey;

        // Full-size line checks: line 0/1 at pd 50, pd 20 written mid line 1, pd 0 written in line 2.
        vecs[0]  = '{0,    6'd50, 5'd0,  1'b0, 1'b0, 3'd0};
        vecs[1]  = '{49,   6'd50, 5'd0,  1'b0, 1'b0, 3'd1};
        vecs[2]  = '{50,   6'd50, 5'd1,  1'b0, 1'b0, 3'd2};
        vecs[3]  = '{1599, 6'd50, 5'd31, 1'b0, 1'b0, 3'd7};
        vecs[4]  = '{1600, 6'd50, 5'd31, 1'b0, 1'b1, 3'd0};
        vecs[5]  = '{1668, 6'd50, 5'd31, 1'b0, 1'b1, 3'd4};
        vecs[6]  = '{1669, 6'd50, 5'd31, 1'b1, 1'b1, 3'd5};
        vecs[7]  = '{1912, 6'd50, 5'd31, 1'b1, 1'b1, 3'd0};
        vecs[8]  = '{1913, 6'd50, 5'd31, 1'b0, 1'b1, 3'd1};
        vecs[9]  = '{2033, 6'd50, 5'd31, 1'b0, 1'b1, 3'd1};
        vecs[10] = '{2034, 6'd50, 5'd0,  1'b0, 1'b0, 3'd0};
        vecs[11] = '{2534, 6'd20, 5'd10, 1'b0, 1'b0, 3'd4};
        vecs[12] = '{3633, 6'd20, 5'd31, 1'b0, 1'b0, 3'd7};
        vecs[13] = '{3634, 6'd20, 5'd31, 1'b0, 1'b1, 3'd0};
        vecs[14] = '{4068, 6'd20, 5'd0,  1'b0, 1'b0, 3'd0};
        vecs[15] = '{4687, 6'd20, 5'd30, 1'b0, 1'b0, 3'd3};
        vecs[16] = '{4688, 6'd20, 5'd31, 1'b0, 1'b0, 3'd4};
        vecs[17] = '{4707, 6'd20, 5'd31, 1'b0, 1'b0, 3'd7};
        vecs[18] = '{4708, 6'd20, 5'd31, 1'b0, 1'b1, 3'd0};
        vecs[19] = '{4768, 6'd0,  5'd31, 1'b0, 1'b1, 3'd4};
        vecs[20] = '{6102, 6'd0,  5'd0,  1'b0, 1'b0, 3'd0};
        vecs[21] = '{6107, 6'd0,  5'd5,  1'b0, 1'b0, 3'd5};
        vecs[22] = '{6133, 6'd0,  5'd31, 1'b0, 1'b0, 3'd7};
        vecs[23] = '{6134, 6'd0,  5'd31, 1'b0, 1'b1, 3'd0};
        vecs[24] = '{7102, 6'd0,  5'd31, 1'b0, 1'b1, 3'd0};

        pix_div = 6'd50;
        row_div = 6'd30;
        reset_seq();
        for (int i = 0; i < 25; i++) begin
            go_to(vecs[i].cyc);
            pix_div = vecs[i].pd;
            chk($sformatf("big_x@%0d", vecs[i].cyc), b_x, vecs[i].x);
            chk($sformatf("big_hsync@%0d", vecs[i].cyc), b_hs, vecs[i].hs_act ? SON : SOFF);
            chk($sformatf("big_blank@%0d", vecs[i].cyc), b_bl, vecs[i].bl);
            chk($sformatf("big_counter@%0d", vecs[i].cyc), b_cnt, vecs[i].cnt);
            chk($sformatf("big_y@%0d", vecs[i].cyc), b_y, 0);
            chk($sformatf("big_vsync@%0d", vecs[i].cyc), b_vs, SOFF);
            chk($sformatf("big_int@%0d", vecs[i].cyc), b_int, 0);
        end

        // Shrunken frame, row_div=3: rows, vsync placement, frame period and interrupt set/clear.
        pix_div = 6'd2;
        row_div = 6'd3;
        cli = 1'b0;
        reset_seq();
        vs_cnt = 0;
        nfall = 0;
        fall0 = -1;
        fall1 = -1;
        prev_vs = SOFF;
        for (int c = 0; c <= S_FRAME + 3140; c++) begin
            if (c > 0) @(negedge clk);
            h  = c % SH_TOT;
            ln = (c / SH_TOT) % SV_TOT;
            if (h == 0) begin
                ey = (ln / 3 > 15) ? 15 : ln / 3;
                chk($sformatf("sm_y@line%0d", ln), s_y, ey);
                chk($sformatf("sm_blank@line%0d", ln), s_bl, (ln >= 48) ? 1 : 0);
                chk($sformatf("sm_vsync@line%0d", ln), s_vs, (ln >= 51 && ln < 53) ? SON : SOFF);
            end
            if (s_vs == SON && c < S_FRAME) vs_cnt++;
            if (s_vs == SON && prev_vs != SON) begin
                if (nfall == 0) fall0 = c;
                else if (nfall == 1) fall1 = c;
                nfall++;
            end
            prev_vs = s_vs;
            case (c)
                2879, 2891, 2896, 6359: chk($sformatf("sm_int@%0d", c), s_int, 0);
                2880, 2890, 6360, 6361: chk($sformatf("sm_int@%0d", c), s_int, 1);
                S_FRAME + 3140: begin
                    chk("sm_int_held", s_int, 1);
                    chk("sm_x_before_rst", s_x, 10);
                    chk("sm_counter_before_rst", s_cnt, 4);
                end
                default: ;
            endcase
            cli = (c == 2890) || (c == 2895) || (c == 6360);
        end
        cli = 1'b0;
        chk("sm_vsync_low_cycles", vs_cnt, 2 * SH_TOT);
        chk("sm_vsync_first_fall", fall0, 51 * SH_TOT);
        chk("sm_frame_period", fall1 - fall0, S_FRAME);

        // One-cycle reset at line 52, h 20 (vsync active, interrupt pending).
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_x", s_x, 0);
        chk("rst_y", s_y, 0);
        chk("rst_hsync", s_hs, SOFF);
        chk("rst_vsync", s_vs, SOFF);
        chk("rst_blank", s_bl, 0);
        chk("rst_counter", s_cnt, 0);
        chk("rst_int", s_int, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_counter1", s_cnt, 1);
        chk("post_rst_x1", s_x, 0);
        @(negedge clk);
        chk("post_rst_x2", s_x, 1);
        chk("post_rst_counter2", s_cnt, 2);

        // Shrunken frame, row_div=0: one row per line, row overflow from line 16.
        row_div = 6'd0;
        reset_seq();
        for (int c = 0; c < S_FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (c % SH_TOT == 0) begin
                ln = c / SH_TOT;
                chk($sformatf("rd0_y@line%0d", ln), s_y, (ln > 15) ? 15 : ln);
                chk($sformatf("rd0_blank@line%0d", ln), s_bl, (ln >= 16) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tqvp_htfab_vga_sync_gen.md
# tqvp_htfab_vga_sync_gen

Programmable VGA timing generator for the baby VGA peripheral. It counts 64 MHz system clocks into 640x480@60 Hz line and frame timing, and drives the negative-polarity hsync and vsync strobes. It also produces the 32x16 framebuffer cell coordinates, a blanking flag, a 3-bit framebuffer read-phase counter and a start-of-vblank interrupt. It sits directly upstream of the framebuffer read port and the pixel output register.

## Interface
Parameters:
- H_ACTIVE, 1628: active clocks per line
- H_FP, 41: front porch clocks
- H_SYNC, 244: hsync pulse clocks
- H_BP, 121: back porch clocks (total 2034 clocks per line)
- V_ACTIVE, 480: active lines
- V_FP, 10: front porch lines
- V_SYNC, 2: vsync pulse lines
- V_BP, 33: back porch lines (total 525 lines)

Ports:
- clk  in  1  system clock (64 MHz)
- rst_n  in  1  reset, synchronous, active-low
- cli  in  1  one-cycle pulse that clears the interrupt
- pix_div  in  6  clocks per framebuffer column (reset default in parent: 50)
- row_div  in  6  lines per framebuffer row (reset default in parent: 30)
- x_pos  out  5  current column, 0..31
- y_pos  out  4  current row, 0..15
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  high when no pixel may be shown
- counter  out  3  read-phase counter
- interrupt  out  1  start-of-vblank flag, level

## Operation
- h_cnt runs 0..2033 and wraps to 0. When h_cnt wraps, v_cnt advances 0..524 and wraps to 0.
- Line order: active [0, H_ACTIVE), front porch, sync, back porch. Frame order follows the same pattern using lines.
- hsync is low while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is low for the whole of lines [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Column logic:
  - Sub-counter counts 0..pd-1. On reaching pd-1, x_pos increments.
  - pd is pix_div, sampled when h_cnt==0 and held for the whole line. A value of 0 is treated as 1.
  - Incrementing from 31 sets col_ovf instead of wrapping.
  - x_pos, the sub-counter and col_ovf all clear at h_cnt==0.
- Row logic:
  - Line-in-row counter counts 0..rd-1. On reaching rd-1, at the h_cnt wrap, y_pos increments.
  - rd is row_div, sampled when v_cnt==0 and h_cnt==0. A value of 0 is treated as 1.
  - Incrementing from 15 sets row_ovf.
  - All row state clears when v_cnt wraps to 0.
- blank = (h_cnt >= H_ACTIVE) | (v_cnt >= V_ACTIVE) | col_ovf | row_ovf.
- counter increments every clock, wraps 7->0, and is forced to 0 at h_cnt==0.
- Interrupt:
  - Set at h_cnt==0 on the first line of vertical blanking (v_cnt==V_ACTIVE).
  - Cleared by cli.
  - If set and clear land on the same cycle, set wins.
  - The flag stays high across frames until it is cleared.

## Timing
- All outputs are registered and reflect the counter state of the same cycle. There is no additional pipeline.
- The parent adds one output register stage for pixel, hsync and vsync, so their mutual alignment is preserved.
- Reset values: h_cnt=0, v_cnt=0, x_pos=0, y_pos=0, counter=0, hsync=1, vsync=1, blank=0, interrupt=0, col_ovf=0, row_ovf=0.
- Reset asserted mid-frame: all state returns to the reset values on the next clock edge. The first cycle after release is h_cnt=0, line 0.
- A divisor change takes effect at the next line (pix_div) or next frame (row_div), never mid-line.
- cli arriving while interrupt is already low has no effect.

## Configuration
- VGA_SYNC_INVERT_EN:
  - When defined, hsync and vsync are active high and reset to 0.
  - When undefined, they are active low and reset to 1.
- Blank, position and interrupt behaviour are identical in both cases.

## Test plan
- Reset, then run one line with pix_div=50: hsync falls at cycle 1669 and rises at 1913. blank goes 0->1 at cycle 1600 (col_ovf) and returns to 0 at cycle 2034.
- Run a full frame with row_div=30: y_pos steps every 30 lines and reaches 15 at line 450. vsync is low only on lines 490-491. The frame is exactly 525*2034 clocks.
- Interrupt: rises at line 480, h_cnt 0. A cli pulse 10 cycles later drops it. A cli coinciding with the next frame's set cycle leaves it at 1.
- pix_div=0 and row_div=0: x_pos steps every clock and col_ovf is set at clock 32. blank stays 1 for the rest of the line.
- Write pix_div=20 at h_cnt=500: the current line keeps a 50-clock column. The next line shows x_pos=31 at h_cnt 620-639 and blank at 640.
- Assert rst_n=0 at line 300, h_cnt 900, for 1 cycle: all outputs return to reset values. Build with VGA_SYNC_INVERT_EN: sync pulses go high and rest low.
